// File: rtl/health_bar_renderer.sv
// health_bar_renderer
//
// Owns one fighter's health and draws that fighter's health bar as a 24-bit
// display layer. A pixel value of 0 means transparent.
//
// Damage strobes reduce health, with saturation at zero. Each damage strobe
// also starts a short white hit flash. Once per frame, a red "ghost" segment
// drains toward the current health. The renderer reads only the per-frame
// snapshot registers, so the bar never changes in the middle of a frame.
//
// Ports
//   clk_in           pixel clock
//   rst_in           synchronous, active-high reset
//   hcount_in        raster x (11 bits)
//   vcount_in        raster y (10 bits)
//   new_frame_in     one-cycle pulse at frame start
//   round_start_in   one-cycle pulse: refill health and leave KO
//   damage_valid_in  one-cycle damage strobe
//   damage_in        damage amount
//   health_out       current health (registered)
//   ko_out           high while knocked out (registered)
//   pixel_out        layer colour, 2 cycles after hcount_in/vcount_in
module health_bar_renderer #(
  parameter int X0           = 32,
  parameter int Y0           = 16,
  parameter int BAR_H        = 16,
  parameter int MAX_HEALTH   = 200,
  parameter int FLASH_FRAMES = 8,
  parameter int MIRROR       = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        round_start_in,
  input  logic        damage_valid_in,
  input  logic [7:0]  damage_in,
  output logic [7:0]  health_out,
  output logic        ko_out,
  output logic [23:0] pixel_out
);

  localparam logic [7:0]  HEALTH_FULL = 8'(MAX_HEALTH);
  localparam logic [7:0]  FLASH_LOAD  = 8'(FLASH_FRAMES);
  localparam logic [7:0]  O_LAST      = 8'(MAX_HEALTH - 1);
  localparam logic [10:0] X_LO        = 11'(X0);
  localparam logic [10:0] X_HI        = 11'(X0 + MAX_HEALTH - 1);
  localparam logic [9:0]  Y_LO        = 10'(Y0);
  localparam logic [9:0]  Y_HI        = 10'(Y0 + BAR_H - 1);

  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_EMPTY = 24'h202020;
  localparam logic [23:0] C_KO    = 24'h400000;

  typedef enum logic {FIGHT, KO} state_t;

  state_t     state;
  logic [7:0] health;
  logic [7:0] ghost;
  logic [7:0] flash;
  logic [7:0] snap_health;
  logic [7:0] snap_ghost;
  // Only bit 1 of the flash counter decides the flash colour, so the
  // snapshot keeps only that bit.
  logic       snap_flash_hi;

  // Subtraction that saturates at zero. Operands are widened to signed
  // 10 bits so a negative result can be detected without wrap-around.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic signed [9:0] diff;
    diff = $signed({2'b00, a}) - $signed({2'b00, b});
    return (diff < 0) ? 8'd0 : diff[7:0];
  endfunction

  // Colour inside the bar box, in priority order.
  function automatic logic [23:0] bar_colour(input logic       border,
                                             input logic [7:0] o,
                                             input logic [7:0] sh,
                                             input logic [7:0] sg,
                                             input logic       flash_hi,
                                             input logic       ko);
    if (border)       return C_WHITE;
    else if (o < sh)  return flash_hi ? C_WHITE : C_GREEN;
    else if (o < sg)  return C_RED;
    else              return ko ? C_KO : C_EMPTY;
  endfunction

  logic [7:0] dmg_health;
  assign dmg_health = sat_sub(health, damage_in);
  assign health_out = health;

  // Game state. Updates in program order: the frame tick runs first, then
  // round_start or damage. This order has three effects:
  // - Damage overrides the flash decrement on a coincident frame tick.
  // - round_start overrides everything except the snapshot.
  // - Both the snapshot and the ghost compare use pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= FIGHT;
      ko_out        <= 1'b0;
      health        <= HEALTH_FULL;
      ghost         <= HEALTH_FULL;
      flash         <= 8'd0;
      snap_health   <= HEALTH_FULL;
      snap_ghost    <= HEALTH_FULL;
      snap_flash_hi <= 1'b0;
    end else begin
      if (new_frame_in) begin
        snap_health   <= health;
        snap_ghost    <= ghost;
        snap_flash_hi <= flash[1];
        if (ghost > health)      ghost <= ghost - 8'd1;
        else if (ghost < health) ghost <= health;
        if (flash != 8'd0)       flash <= flash - 8'd1;
      end
      if (round_start_in) begin
        health <= HEALTH_FULL;
        ghost  <= HEALTH_FULL;
        flash  <= 8'd0;
        state  <= FIGHT;
        ko_out <= 1'b0;
      end else if (state == FIGHT && damage_valid_in) begin
        health <= dmg_health;
        flash  <= FLASH_LOAD;
        if (dmg_health == 8'd0) begin
          state  <= KO;
          ko_out <= 1'b1;
        end
      end
    end
  end

  // Raster decode, feeding pipeline stage 1.
  logic       in_box_c;
  logic       border_c;
  logic [7:0] dx;
  logic [7:0] o_c;

  assign in_box_c = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                    (vcount_in >= Y_LO) && (vcount_in <= Y_HI);
  assign border_c = (vcount_in == Y_LO) || (vcount_in == Y_HI);
  // Modulo-256 arithmetic is sufficient: the offset only matters inside the box.
  assign dx       = hcount_in[7:0] - X_LO[7:0];
  assign o_c      = (MIRROR != 0) ? (O_LAST - dx) : dx;

  // Stage 1: box membership, border flag and bar offset.
  logic       in_box_p1;
  logic       border_p1;
  logic [7:0] o_p1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_box_p1 <= 1'b0;
      border_p1 <= 1'b0;
      o_p1      <= 8'd0;
    end else begin
      in_box_p1 <= in_box_c;
      border_p1 <= border_c;
      o_p1      <= o_c;
    end
  end

  // Stage 2: colour lookup against the frame snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out <= 24'h000000;
    end else if (in_box_p1) begin
      pixel_out <= bar_colour(border_p1, o_p1, snap_health, snap_ghost,
                              snap_flash_hi, ko_out);
    end else begin
      pixel_out <= 24'h000000;
    end
  end

endmodule

// File: tb/tb_health_bar_renderer.sv
module tb_health_bar_renderer;

  localparam int X0 = 32;
  localparam int Y0 = 16;
  localparam logic [23:0] WH = 24'hFFFFFF;
  localparam logic [23:0] GR = 24'h00FF00;
  localparam logic [23:0] RD = 24'hFF0000;
  localparam logic [23:0] EM = 24'h202020;
  localparam logic [23:0] KB = 24'h400000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic        nf = 1'b0;
  logic        rs = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  dmg = '0;
  logic        rs_m = 1'b0;
  logic        dv_m = 1'b0;
  logic [7:0]  dmg_m = '0;
  logic [7:0]  health, health_m;
  logic        ko, ko_m;
  logic [23:0] pix, pix_m;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  health_bar_renderer #(.MIRROR(0)) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .new_frame_in(nf), .round_start_in(rs), .damage_valid_in(dv),
    .damage_in(dmg), .health_out(health), .ko_out(ko), .pixel_out(pix));

  health_bar_renderer #(.MIRROR(1)) dut_m (
    .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .new_frame_in(nf), .round_start_in(rs_m), .damage_valid_in(dv_m),
    .damage_in(dmg_m), .health_out(health_m), .ko_out(ko_m), .pixel_out(pix_m));

  // Stimulus helpers.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); nf = 1'b1;
      @(negedge clk); nf = 1'b0;
    end
  endtask

  task automatic hit(input logic [7:0] d);
    @(negedge clk); dv = 1'b1; dmg = d;
    @(negedge clk); dv = 1'b0; dmg = '0;
  endtask

  // Drive one raster position, queue its expected colour, and return once
  // that pixel is at the DUT output.
  task automatic drive_pt(input int x, input int y, input logic [23:0] e);
    @(negedge clk); hc = 11'(x); vc = 10'(y);
    exp_q.push_back(e);
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int xs[6] = '{X0+10, X0,  X0+200, X0+199, X0-1, X0+5};
    int ys[6] = '{Y0+5,  Y0,  Y0+5,   Y0+15,  Y0+5, Y0+16};
    logic [23:0] es[6] = '{GR, WH, 24'h0, WH, 24'h0, 24'h0};
    logic [23:0] got, want;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pix !== 24'h0) begin miscompares++; $display("FAIL reset_pixel: got %h want 000000", pix); end
    vectors++;
    if (health !== 8'd200 || ko !== 1'b0) begin
      miscompares++; $display("FAIL reset_state: health %0d ko %b want 200 0", health, ko);
    end
    vectors++;
    if (health_m !== 8'd200) begin miscompares++; $display("FAIL reset_mirror_health: got %0d want 200", health_m); end
    @(negedge clk); rst = 1'b0;
    frames(1);
    for (int i = 0; i < 6; i++) begin
      drive_pt(xs[i], ys[i], es[i]);
      got = pix; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reset_px%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_damage;
    int xs[4] = '{X0+149, X0+150, X0+160, X0+199};
    logic [23:0] es[4] = '{WH, RD, RD, EM};
    logic [23:0] got, want;
    hit(8'd50);
    vectors++;
    if (health !== 8'd150) begin miscompares++; $display("FAIL damage_health: got %0d want 150", health); end
    frames(2);
    for (int i = 0; i < 4; i++) begin
      drive_pt(xs[i], Y0+5, es[i]);
      got = pix; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL damage_px%0d: got %h want %h", i, got, want); end
    end
    frames(50);
    drive_pt(X0+149, Y0+5, GR);
    got = pix; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL drained_o149: got %h want %h", got, want); end
    drive_pt(X0+150, Y0+5, EM);
    got = pix; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL drained_o150: got %h want %h", got, want); end
  endtask

  task automatic test_coincident;
    int xs[4] = '{X0+129, X0+130, X0+149, X0+150};
    logic [23:0] es[4] = '{GR, RD, RD, EM};
    logic [23:0] got, want;
    @(negedge clk); dv = 1'b1; dmg = 8'd20; nf = 1'b1;
    @(negedge clk); dv = 1'b0; dmg = '0;    nf = 1'b0;
    vectors++;
    if (health !== 8'd130) begin miscompares++; $display("FAIL coinc_health: got %0d want 130", health); end
    drive_pt(X0+140, Y0+5, GR);
    got = pix; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL coinc_old_snap: got %h want %h", got, want); end
    drive_pt(X0+150, Y0+5, EM);
    got = pix; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL coinc_old_edge: got %h want %h", got, want); end
    frames(1);
    for (int i = 0; i < 4; i++) begin
      drive_pt(xs[i], Y0+5, es[i]);
      got = pix; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL coinc_new_px%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_ko;
    int xs[3] = '{X0+10, X0+199, X0+10};
    int ys[3] = '{Y0+5,  Y0+8,   Y0};
    logic [23:0] es[3] = '{KB, KB, WH};
    logic [23:0] got, want;
    hit(8'd250);
    vectors++;
    if (health !== 8'd0 || ko !== 1'b1) begin
      miscompares++; $display("FAIL ko_enter: health %0d ko %b want 0 1", health, ko);
    end
    hit(8'd10);
    vectors++;
    if (health !== 8'd0 || ko !== 1'b1) begin
      miscompares++; $display("FAIL ko_ignore_damage: health %0d ko %b want 0 1", health, ko);
    end
    frames(160);
    for (int i = 0; i < 3; i++) begin
      drive_pt(xs[i], ys[i], es[i]);
      got = pix; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL ko_px%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_round_in_ko;
    logic [23:0] got, want;
    @(negedge clk); rs = 1'b1; dv = 1'b1; dmg = 8'd30;
    @(negedge clk); rs = 1'b0; dv = 1'b0; dmg = '0;
    vectors++;
    if (health !== 8'd200 || ko !== 1'b0) begin
      miscompares++; $display("FAIL round_start: health %0d ko %b want 200 0", health, ko);
    end
    frames(1);
    drive_pt(X0+199, Y0+5, GR);
    got = pix; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL round_full_bar: got %h want %h", got, want); end
  endtask

  // Stream two full raster rows, one pixel per clock, through the pipeline.
  task automatic test_back_to_back;
    int n;
    int x;
    int y;
    logic [23:0] got, want;
    n = 2 * 204;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        @(negedge clk);
        x = X0 - 2 + (c % 204);
        y = (c < 204) ? Y0 + 5 : Y0;
        hc = 11'(x); vc = 10'(y);
        if (x < X0 || x > X0 + 199) exp_q.push_back(24'h0);
        else if (y == Y0)           exp_q.push_back(WH);
        else                        exp_q.push_back(GR);
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        got = pix; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("FAIL stream_px%0d: got %h want %h", c - 1, got, want); end
      end
    end
  endtask

  task automatic test_mirror;
    int xs[6] = '{X0+150, X0+50, X0+99, X0+100, X0+199, X0};
    logic [23:0] es[6] = '{GR, EM, EM, GR, GR, EM};
    logic [23:0] got, want;
    @(negedge clk); dv_m = 1'b1; dmg_m = 8'd100;
    @(negedge clk); dv_m = 1'b0; dmg_m = '0;
    vectors++;
    if (health_m !== 8'd100 || ko_m !== 1'b0) begin
      miscompares++; $display("FAIL mirror_health: health %0d ko %b want 100 0", health_m, ko_m);
    end
    frames(105);
    for (int i = 0; i < 6; i++) begin
      drive_pt(xs[i], Y0+5, es[i]);
      got = pix_m; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL mirror_px%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk); hc = 11'(X0+10); vc = 10'(Y0+5);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pix !== GR) begin miscompares++; $display("FAIL midrst_before: got %h want %h", pix, GR); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (pix !== 24'h0) begin miscompares++; $display("FAIL midrst_edge: got %h want 000000", pix); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (pix !== 24'h0) begin miscompares++; $display("FAIL midrst_next: got %h want 000000", pix); end
    @(posedge clk); #1;
    vectors++;
    if (pix !== GR) begin miscompares++; $display("FAIL midrst_resume: got %h want %h", pix, GR); end
    vectors++;
    if (health_m !== 8'd200 || ko_m !== 1'b0) begin
      miscompares++; $display("FAIL midrst_mirror_health: health %0d ko %b want 200 0", health_m, ko_m);
    end
  endtask

  initial begin
    test_reset;
    test_damage;
    test_coincident;
    test_ko;
    test_round_in_ko;
    test_back_to_back;
    test_mirror;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/health_bar_renderer.md
# health_bar_renderer

Per-player health bar layer generator for the fencing game display. It owns one fighter's health, applies damage events, and animates a draining "ghost" segment and a hit flash once per frame. It renders a 24-bit layer pixel from the raster position. Two instances, one normal and one mirrored, drive the player and opponent health layers of the display compositing mux. A zero pixel means transparent.

## Interface
Parameters:
- X0, 32: left x of bar bounding box (pixels)
- Y0, 16: top y of bar bounding box
- BAR_H, 16: bar height in lines
- MAX_HEALTH, 200: full health; bar width in pixels equals MAX_HEALTH (≤255)
- FLASH_FRAMES, 8: frames of hit flash after accepted damage
- MIRROR, 0: 1 = bar fills from right edge (opponent)

Ports:
- clk_in  input  1  pixel clock; the only clock
- rst_in  input  1  reset; synchronous, active-high
- hcount_in  input  11  raster x
- vcount_in  input  10  raster y
- new_frame_in  input  1  single-cycle pulse at frame start, outside active video
- round_start_in  input  1  single-cycle pulse; refill health, leave KO
- damage_valid_in  input  1  single-cycle damage strobe
- damage_in  input  8  damage amount, qualified by damage_valid_in
- health_out  output  8  current health
- ko_out  output  1  high while in KO state
- pixel_out  output  24  layer RGB; 0 = transparent

## Operation
- State machine has two states, FIGHT and KO. Reset enters FIGHT.
- Internal registers, all cleared to these values on reset:
  - health = MAX_HEALTH
  - ghost = MAX_HEALTH
  - flash = 0
  - snapshot registers snap_health = MAX_HEALTH, snap_ghost = MAX_HEALTH, snap_flash = 0
- FIGHT + damage_valid_in:
  - health ← health − damage_in, saturating at 0 (9-bit compare, no wrap).
  - flash ← FLASH_FRAMES.
  - If the new health is 0, go to KO.
  - damage_in = 0 is accepted and still loads flash.
- KO: damage_valid_in is ignored. flash keeps counting down. ghost keeps draining.
- round_start_in, in either state:
  - health ← MAX_HEALTH, ghost ← MAX_HEALTH, flash ← 0; state ← FIGHT.
  - Takes priority over a same-cycle damage_valid_in, which is dropped.
- new_frame_in:
  - If ghost > health, ghost ← ghost − 1. If ghost < health, ghost ← health.
  - If flash ≠ 0, flash ← flash − 1.
  - Snapshot registers load the pre-update values of health, ghost and flash. Rendering uses only the snapshots, so no tearing occurs mid-frame.
- damage_valid_in and new_frame_in in the same cycle:
  - Damage applies to health and flash.
  - The ghost decrement is computed against the old health.
  - The snapshot takes the old values.
- Render region: bar box is x ∈ [X0, X0+MAX_HEALTH−1], y ∈ [Y0, Y0+BAR_H−1].
  - Offset o = hcount_in − X0, or MAX_HEALTH−1−(hcount_in−X0) when MIRROR=1.
- Colour priority inside the box:
  1. Top or bottom line of the box → 24'hFFFFFF.
  2. o < snap_health → 24'hFFFFFF if snap_flash[1] = 1, else 24'h00FF00.
  3. o < snap_ghost → 24'hFF0000.
  4. Otherwise → 24'h202020, or 24'h400000 when ko_out = 1.
- Outside the box → 24'h000000.
- health_out and ko_out are registered and reflect state updates one cycle after the causing input.

## Timing
- Pixel path is a 2-stage pipeline, so pixel_out corresponds to the hcount/vcount presented 2 cycles earlier.
  - Stage 1 registers in_box, border and o.
  - Stage 2 registers the colour.
- Reset values: pixel_out = 0, health_out = MAX_HEALTH, ko_out = 0. Pipeline stages clear to "outside box".
- Reset asserted mid-frame: all state reloads on the next edge, and pixel_out is 0 for that cycle and the following one.
- Damage-to-visible latency: at the first new_frame_in after the damage cycle. The snapshot updates there; visible in the frame after (one-frame lag by design).
- The ghost drains 1 px per frame, so a full drain from 200 to 0 takes 200 frames.
- Flash visibility depends only on snap_flash[1]. With FLASH_FRAMES = 8, frames with snapshot 7, 6, 3, 2 show white.

## Test plan
- Reset, then one frame:
  - health_out = 200, ko_out = 0.
  - Pixel at (X0+10, Y0+5), 2 cycles later = 24'h00FF00.
  - Pixel at (X0, Y0) = 24'hFFFFFF.
  - Pixel at (X0+200, Y0+5) = 0.
- damage 50, then two new_frame_in pulses:
  - health_out = 150.
  - o = 149 is flash colour or green. o = 160 is red (ghost 200). o = 150 is red.
  - After 50 more frames, o = 150 is 24'h202020.
- damage 250 at health 150:
  - health_out = 0 and ko_out = 1 next cycle.
  - A further damage 10 leaves both unchanged.
  - Interior renders 24'h400000 once the ghost drains.
- round_start_in and damage_valid_in (damage 30) in the same cycle while in KO: health_out = 200, ko_out = 0, damage dropped.
- MIRROR = 1, health 100: pixel at x = X0+150 is green; pixel at x = X0+50 is 24'h202020 after the ghost drains.
- damage_valid_in coincident with new_frame_in: the snapshot holds the old health for the frame, and the next frame shows the new health.
